// File: rtl/simon_seq_ctrl.sv
// rtl/simon_seq_ctrl.sv - Simon memory-game sequencer; define SIMON_TIMEOUT_EN to fail on idle player input
module simon_seq_ctrl #(
    parameter int         MAX_LEN       = 16,
    parameter int         ON_TICKS      = 25000000,
    parameter int         OFF_TICKS     = 12500000,
    parameter int         TIMEOUT_TICKS = 250000000,
    parameter logic [7:0] SEED          = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [4:0] level,
    output logic       player_turn,
    output logic       win,
    output logic       fail
);

    localparam int CNT_MAX = (ON_TICKS > OFF_TICKS)
                           ? ((ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS)
                           : ((OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS);
    localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int IW = $clog2(MAX_LEN);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_TICKS - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_TICKS - 1);
`endif
    localparam logic [4:0]    LAST_IDX = 5'(MAX_LEN - 1);
    localparam logic [4:0]    TOP_LVL  = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, FAIL
    } state_t;

    state_t        state;
    logic [7:0]    lfsr;
    logic [4:0]    idx;
    logic [CW-1:0] cnt;
    logic [1:0]    mem [MAX_LEN];

    logic [4:0]    idx_nxt;
    logic [3:0]    want;
    logic          at_last;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign idx_nxt = idx + 5'd1;
    assign want    = onehot(mem[idx[IW-1:0]]);
    assign at_last = (idx == level - 5'd1);

    // Sequence memory is deliberately left out of reset; GEN rewrites every slot.
    always_ff @(posedge clk) begin
        if (state == GEN)
            mem[idx[IW-1:0]] <= lfsr[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            led         <= 4'h0;
            level       <= 5'd0;
            player_turn <= 1'b0;
            win         <= 1'b0;
            fail        <= 1'b0;
            idx         <= 5'd0;
            cnt         <= '0;
            lfsr        <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= GEN;
                        idx   <= 5'd0;
                    end
                end
                GEN: begin
                    if (idx == LAST_IDX) begin
                        state <= SHOW_ON;
                        level <= 5'd1;
                        idx   <= 5'd0;
                        cnt   <= ON_LOAD;
                        led   <= onehot(mem[0]);
                    end else begin
                        idx <= idx_nxt;
                    end
                end
                SHOW_ON: begin
                    if (cnt == '0) begin
                        state <= SHOW_OFF;
                        led   <= 4'h0;
                        cnt   <= OFF_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHOW_OFF: begin
                    if (cnt == '0) begin
                        if (at_last) begin
                            state       <= WAIT_IN;
                            idx         <= 5'd0;
                            player_turn <= 1'b1;
`ifdef SIMON_TIMEOUT_EN
                            cnt         <= TO_LOAD;
`endif
                        end else begin
                            state <= SHOW_ON;
                            idx   <= idx_nxt;
                            led   <= onehot(mem[idx_nxt[IW-1:0]]);
                            cnt   <= ON_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_IN: begin
                    if (btn == want) begin
                        if (at_last) begin
                            player_turn <= 1'b0;
                            if (level == TOP_LVL) begin
                                state <= WIN;
                                win   <= 1'b1;
                                led   <= 4'hF;
                            end else begin
                                state <= SHOW_ON;
                                level <= level + 5'd1;
                                idx   <= 5'd0;
                                cnt   <= ON_LOAD;
                                led   <= onehot(mem[0]);
                            end
                        end else begin
                            idx <= idx_nxt;
`ifdef SIMON_TIMEOUT_EN
                            cnt <= TO_LOAD;
`endif
                        end
                    end else if (btn != 4'h0) begin
                        state       <= FAIL;
                        fail        <= 1'b1;
                        player_turn <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
                    end else if (cnt == '0) begin
                        state       <= FAIL;
                        fail        <= 1'b1;
                        player_turn <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
`endif
                    end
                end
                WIN, FAIL: begin
                    if (start) begin
                        state <= GEN;
                        idx   <= 5'd0;
                        win   <= 1'b0;
                        fail  <= 1'b0;
                        led   <= 4'h0;
                        level <= 5'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb/tb_simon_seq_ctrl.sv - randomized game-level reference check of simon_seq_ctrl
module tb_simon_seq_ctrl;

    localparam int         MAX_LEN = 4;
    localparam int         ON_T    = 3;
    localparam int         OFF_T   = 2;
    localparam int         TO_T    = 20;
    localparam logic [7:0] SEED    = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'h0;
    logic [3:0] led;
    logic [4:0] level;
    logic       player_turn, win, fail;

    simon_seq_ctrl #(
        .MAX_LEN(MAX_LEN), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T),
        .TIMEOUT_TICKS(TO_T), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .led(led),
        .level(level), .player_turn(player_turn), .win(win), .fail(fail)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_led;
    logic [4:0] exp_level;
    logic       exp_pt, exp_win, exp_fail;
    bit         chk_en = 1'b0;

    int ecnt = 0;
    int seq [MAX_LEN];

    // Rising edges seen since reset release: the LFSR has stepped this many times.
    always @(posedge clk or negedge reset) begin
        if (!reset) ecnt = 0;
        else        ecnt++;
    end

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] v;
        v = SEED;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    function automatic logic [3:0] oh(input int c);
        case (c)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("led", 32'(led), 32'(exp_led));
            check("level", 32'(level), 32'(exp_level));
            check("player_turn", 32'(player_turn), 32'(exp_pt));
            check("win", 32'(win), 32'(exp_win));
            check("fail", 32'(fail), 32'(exp_fail));
        end
    end

    task automatic tick(input logic [3:0] l, input int lv, input logic pt, input logic w, input logic f);
        @(posedge clk);
        #1;
        exp_led   = l;
        exp_level = 5'(lv);
        exp_pt    = pt;
        exp_win   = w;
        exp_fail  = f;
        chk_en    = 1'b1;
        start     = 1'b0;
        btn       = 4'h0;
    endtask

    task automatic noise();
        start = ($urandom_range(0, 3) == 0);
    endtask

    task automatic begin_game();
        logic [7:0] v;
        int c;
        start = 1'b1;
        tick(4'h0, 0, 0, 0, 0);
        c = ecnt;
        for (int k = 0; k < MAX_LEN; k++) begin
            v = lfsr_at(c + k);
            seq[k] = int'(v[1:0]);
        end
        repeat (MAX_LEN - 1) begin
            noise();
            tick(4'h0, 0, 0, 0, 0);
        end
    endtask

    task automatic replay(input int lv);
        for (int i = 0; i < lv; i++) begin
            repeat (ON_T) begin
                noise();
                tick(oh(seq[i]), lv, 0, 0, 0);
            end
            repeat (OFF_T) begin
                noise();
                tick(4'h0, lv, 0, 0, 0);
            end
        end
        noise();
        tick(4'h0, lv, 1, 0, 0);
    endtask

    task automatic idle(input int lv, input int n);
        repeat (n) begin
            noise();
            tick(4'h0, lv, 1, 0, 0);
        end
    endtask

    // fail_lv == 0 plays a perfect game through to WIN.
    task automatic play(input int fail_lv, input int fail_ix, input bit multi);
        for (int lv = 1; lv <= MAX_LEN; lv++) begin
            for (int ix = 0; ix < lv; ix++) begin
                idle(lv, $urandom_range(0, 4));
                if (lv == fail_lv && ix == fail_ix) begin
                    btn = multi ? 4'b0011 : oh((seq[ix] + int'($urandom_range(1, 3))) % 4);
                    tick(4'h0, lv, 0, 0, 1);
                    return;
                end
                btn = oh(seq[ix]);
                if (ix < lv - 1)         tick(4'h0, lv, 1, 0, 0);
                else if (lv == MAX_LEN)  tick(4'hF, lv, 0, 1, 0);
                else                     replay(lv + 1);
            end
        end
    endtask

    task automatic hold_end(input int fail_lv);
        repeat (3) begin
            btn = 4'($urandom_range(1, 15));
            if (fail_lv == 0) tick(4'hF, MAX_LEN, 0, 1, 0);
            else              tick(4'h0, fail_lv, 0, 0, 1);
        end
    endtask

    task automatic do_reset();
        #2;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_level", 32'(level), 32'h0);
        check("async_rst_pt", 32'(player_turn), 32'h0);
        check("async_rst_flags", 32'({win, fail}), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fl, fi;
        bit mb;

        check("lfsr_step1", 32'(lfsr_at(1)), 32'h4A);
        check("lfsr_step2", 32'(lfsr_at(2)), 32'h95);
        check("lfsr_step3", 32'(lfsr_at(3)), 32'h2A);
        check("onehot_blue", 32'(oh(2)), 32'h4);

        repeat (3) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_pt", 32'(player_turn), 32'h0);
        check("rst_flags", 32'({win, fail}), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        repeat (3) begin
            btn = 4'($urandom_range(0, 15));
            tick(4'h0, 0, 0, 0, 0);
        end

        begin_game();
        replay(1);
        play(0, 0, 1'b0);
        hold_end(0);

        begin_game();
        replay(1);
        play(2, 1, 1'b0);
        hold_end(2);

        begin_game();
        replay(1);
        play(3, 0, 1'b1);
        hold_end(3);

        for (int g = 0; g < 5; g++) begin
            fl = $urandom_range(0, MAX_LEN);
            fi = (fl > 0) ? $urandom_range(0, fl - 1) : 0;
            mb = 1'($urandom_range(0, 1));
            begin_game();
            replay(1);
            play(fl, fi, mb);
            hold_end(fl);
        end

        begin_game();
        replay(1);
`ifdef SIMON_TIMEOUT_EN
        idle(1, TO_T - 1);
        tick(4'h0, 1, 0, 0, 1);
`else
        idle(1, 1000);
`endif
        do_reset();

        begin_game();
        tick(oh(seq[0]), 1, 0, 0, 0);
        do_reset();

        begin_game();
        replay(1);
        play(0, 0, 1'b0);
        hold_end(0);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
